psram_responder: RTL and testbench
==================================

// Module: psram_responder
// PURPOSE
//   Cycle-accurate HyperRAM device responder: the target end of the HyperRAM
//   link driven by our PSRAM controller. It decodes the 48-bit CA, applies
//   CR0-programmed 1x/2x initial latency, and serves linear word bursts from
//   an internal array. Its ports are the demuxed DDR halves (IDDR/ODDR side),
//   so it runs at 1:1 on clk. Used on-FPGA as a loopback target and in sim.
// PARAMETERS
//   ADDR_BITS  12        word-address width; array depth 2**ADDR_BITS x 16
//   CR0_RESET  16'h8F1F  CR0 after reset: [7:4]=latency code, [3]=fixed-2x
// PORTS
//   clk           in   1   clock (CK domain)
//   resetn        in   1   reset
//   cs_n          in   1   chip select, active low
//   dq_in_ris     in   8   DQ byte on CK rising edge
//   dq_in_fal     in   8   DQ byte on CK falling edge
//   rwds_in_ris   in   1   RWDS, rising half (write mask, upper byte)
//   rwds_in_fal   in   1   RWDS, falling half (write mask, lower byte)
//   force_2x      in   1   request 2x latency on the next CA (variable mode)
//   dq_out_ris    out  8   read data, upper byte
//   dq_out_fal    out  8   read data, lower byte
//   dq_oe         out  1   1 = responder drives DQ
//   rwds_out_ris  out  1   RWDS driven value, rising half
//   rwds_out_fal  out  1   RWDS driven value, falling half
//   rwds_oe       out  1   1 = responder drives RWDS
//   cr0           out  16  current configuration register 0
//   abort         out  1   1-cycle pulse: cs_n rose before CA completed
// BEHAVIOUR
//   Reset resetn, synchronous, active-low; clock clk. Reset: all outputs 0
//   except cr0=CR0_RESET; state IDLE; array contents not reset.
//   Cycle C0 = first clk with cs_n low. CA bytes: C0 {ris,fal}=CA[47:32],
//   C1=CA[31:16], C2=CA[15:0]. CA[47]=1 read, CA[46]=1 register space.
//   Word addr A = {CA[44:16],CA[2:0]} truncated to ADDR_BITS; wraps mod depth.
//   Latency L from cr0[7:4]: E->3, F->4, 0->5, 1->6, other->6.
//   Double = cr0[3] | force_2x sampled at C0. During C0..C2: rwds_oe=1,
//   rwds_out_ris=rwds_out_fal=Double.
//   States: IDLE -> CA (C0..C2) -> REGW | LAT; LAT -> RDATA | WDATA.
//   REGW (register write, CA[47:46]=01): zero latency; word at C3
//     {ris,fal} loads cr0; stays in REGW ignoring further words.
//   LAT: first data cycle D = C0+1+L (1x) or C0+1+2L (Double).
//   WDATA (memory write): each cycle from D: ris byte written to A[15:8]
//     unless rwds_in_ris=1; fal byte to A[7:0] unless rwds_in_fal=1; A++.
//   RDATA: from D each cycle dq_oe=1, rwds_oe=1, rwds_out_ris=1,
//     rwds_out_fal=0, {dq_out_ris,dq_out_fal}=mem[A] (register read: cr0);
//     A++ per cycle. Array read is prefetched so D carries valid data.
//   Any cycle cs_n=1: next cycle IDLE, dq_oe=rwds_oe=0; partial writes
//     already committed stay. cs_n high during C1/C2 -> abort pulse.
//   cs_n high for one cycle then low again: new C0 on the low cycle.
//   Write and read of same address in one burst impossible (single op).
//   Reset mid-burst: IDLE next cycle, cr0 restored, outputs released.
// TESTING
//   CA 60 00 01 00 00 00, C3 data 8F E7 -> cr0=16'h8FE7, next access L=3.
//   Write CA addr word 5, data BEEF, 1x -> written at C0+4; read word 5
//     -> dq_out=BE/EF at C0+4, rwds_out_ris=1, rwds_out_fal=0.
//   Byte write 12 34 to word 5 with rwds_ris=1,fal=0 -> readback BE34.
//   force_2x=1 at C0 -> rwds_out=1 during C0..C2, first read data at C0+7.
//   cs_n high at C1 -> abort=1 one cycle, dq_oe=rwds_oe=0, no write.
//   Burst read from word 2**ADDR_BITS-1 for 2 words -> mem[last], mem[0].

Source files
------------

// File: rtl/psram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : psram_responder
//  Purpose  : Cycle-accurate HyperRAM target on the demuxed DDR (IDDR/ODDR)
//             side of the link. Decodes the 48-bit CA, applies the CR0
//             latency (1x / 2x), serves linear word bursts from an internal
//             array and accepts CR0 register writes.
//  Revision : 1.0  initial release
// ============================================================================
module psram_responder #(
  parameter int          ADDR_BITS = 12,
  parameter logic [15:0] CR0_RESET = 16'h8F1F
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cs_n,
  input  logic [7:0]  dq_in_ris,
  input  logic [7:0]  dq_in_fal,
  input  logic        rwds_in_ris,
  input  logic        rwds_in_fal,
  input  logic        force_2x,
  output logic [7:0]  dq_out_ris,
  output logic [7:0]  dq_out_fal,
  output logic        dq_oe,
  output logic        rwds_out_ris,
  output logic        rwds_out_fal,
  output logic        rwds_oe,
  output logic [15:0] cr0,
  output logic        abort
);

  localparam int c_depth = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_REGW  = 3'd2,
    S_LAT   = 3'd3,
    S_RDATA = 3'd4,
    S_WDATA = 3'd5
  } state_t;

  // Initial latency in clocks selected by the CR0 latency code.
  function automatic logic [3:0] lat_of(input logic [3:0] code);
    case (code)
      4'hE:    lat_of = 4'd3;
      4'hF:    lat_of = 4'd4;
      4'h0:    lat_of = 4'd5;
      4'h1:    lat_of = 4'd6;
      default: lat_of = 4'd6;
    endcase
  endfunction

  state_t                 r_state,    w_state_nxt;
  logic                   r_ca_cnt2,  w_ca_cnt2_nxt;   // 0: next edge is C1, 1: next edge is C2
  logic                   r_is_read,  w_is_read_nxt;
  logic                   r_is_reg,   w_is_reg_nxt;
  logic                   r_double,   w_double_nxt;
  logic                   r_reg_done, w_reg_done_nxt;
  logic [12:0]            r_ca_hi,    w_ca_hi_nxt;     // CA[44:32]
  logic [15:0]            r_ca_mid,   w_ca_mid_nxt;    // CA[31:16]
  logic [3:0]             r_lat,      w_lat_nxt;       // remaining latency edges
  logic [ADDR_BITS-1:0]   r_addr,     w_addr_nxt;
  logic [15:0]            r_cr0,      w_cr0_nxt;
  logic [15:0]            r_dq_out,   w_dq_out_nxt;
  logic                   r_dq_oe,    w_dq_oe_nxt;
  logic                   r_rwds_oe,  w_rwds_oe_nxt;
  logic                   r_rwds_ris, w_rwds_ris_nxt;
  logic                   r_rwds_fal, w_rwds_fal_nxt;
  logic                   r_abort,    w_abort_nxt;
  logic                   w_mem_we;
  logic [3:0]             w_lat_l;
  logic [15:0]            w_rd_word;

  logic [15:0]            r_mem [0:c_depth-1];

  // Latency count loaded at C2 so that the first data edge lands on C0+1+L (or C0+1+2L).
  assign w_lat_l   = lat_of(r_cr0[7:4]);
  // Register-space reads return CR0; memory reads come straight from the array.
  assign w_rd_word = r_is_reg ? r_cr0 : r_mem[r_addr];

  // Next-state and next-output decode; every registered output defaults to released.
  always_comb begin
    w_state_nxt    = r_state;
    w_ca_cnt2_nxt  = r_ca_cnt2;
    w_is_read_nxt  = r_is_read;
    w_is_reg_nxt   = r_is_reg;
    w_double_nxt   = r_double;
    w_reg_done_nxt = r_reg_done;
    w_ca_hi_nxt    = r_ca_hi;
    w_ca_mid_nxt   = r_ca_mid;
    w_lat_nxt      = r_lat;
    w_addr_nxt     = r_addr;
    w_cr0_nxt      = r_cr0;
    w_dq_out_nxt   = 16'h0000;
    w_dq_oe_nxt    = 1'b0;
    w_rwds_oe_nxt  = 1'b0;
    w_rwds_ris_nxt = 1'b0;
    w_rwds_fal_nxt = 1'b0;
    w_abort_nxt    = 1'b0;
    w_mem_we       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!cs_n) begin
          w_is_read_nxt  = dq_in_ris[7];
          w_is_reg_nxt   = dq_in_ris[6];
          w_ca_hi_nxt    = {dq_in_ris[4:0], dq_in_fal};
          w_double_nxt   = r_cr0[3] | force_2x;
          w_rwds_oe_nxt  = 1'b1;
          w_rwds_ris_nxt = r_cr0[3] | force_2x;
          w_rwds_fal_nxt = r_cr0[3] | force_2x;
          w_ca_cnt2_nxt  = 1'b0;
          w_state_nxt    = S_CA;
        end
      end

      S_CA: begin
        if (cs_n) begin
          // Chip select lost before the CA was complete.
          w_abort_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_rwds_oe_nxt  = 1'b1;
          w_rwds_ris_nxt = r_double;
          w_rwds_fal_nxt = r_double;
          if (!r_ca_cnt2) begin
            w_ca_mid_nxt  = {dq_in_ris, dq_in_fal};
            w_ca_cnt2_nxt = 1'b1;
          end else begin
            w_addr_nxt = ADDR_BITS'({r_ca_hi, r_ca_mid, dq_in_fal[2:0]});
            if (!r_is_read && r_is_reg) begin
              w_reg_done_nxt = 1'b0;
              w_state_nxt    = S_REGW;
            end else begin
              w_lat_nxt   = r_double ? 4'((w_lat_l << 1) - 4'd3) : 4'(w_lat_l - 4'd3);
              w_state_nxt = S_LAT;
            end
          end
        end
      end

      S_REGW: begin
        if (cs_n) begin
          w_state_nxt = S_IDLE;
        end else if (!r_reg_done) begin
          // Only the first word after the CA is taken; the rest are ignored.
          w_cr0_nxt      = {dq_in_ris, dq_in_fal};
          w_reg_done_nxt = 1'b1;
        end
      end

      S_LAT: begin
        if (cs_n) begin
          w_state_nxt = S_IDLE;
        end else if (r_lat == 4'd0) begin
          w_state_nxt = r_is_read ? S_RDATA : S_WDATA;
        end else begin
          w_lat_nxt = r_lat - 4'd1;
        end
      end

      S_RDATA: begin
        if (cs_n) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dq_out_nxt   = w_rd_word;
          w_dq_oe_nxt    = 1'b1;
          w_rwds_oe_nxt  = 1'b1;
          w_rwds_ris_nxt = 1'b1;
          w_addr_nxt     = r_addr + 1'b1;
        end
      end

      S_WDATA: begin
        if (cs_n) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_mem_we   = 1'b1;
          w_addr_nxt = r_addr + 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, CA capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ca_cnt2  <= 1'b0;
      r_is_read  <= 1'b0;
      r_is_reg   <= 1'b0;
      r_double   <= 1'b0;
      r_reg_done <= 1'b0;
      r_ca_hi    <= '0;
      r_ca_mid   <= '0;
      r_lat      <= '0;
      r_addr     <= '0;
      r_cr0      <= CR0_RESET;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_rwds_oe  <= 1'b0;
      r_rwds_ris <= 1'b0;
      r_rwds_fal <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ca_cnt2  <= w_ca_cnt2_nxt;
      r_is_read  <= w_is_read_nxt;
      r_is_reg   <= w_is_reg_nxt;
      r_double   <= w_double_nxt;
      r_reg_done <= w_reg_done_nxt;
      r_ca_hi    <= w_ca_hi_nxt;
      r_ca_mid   <= w_ca_mid_nxt;
      r_lat      <= w_lat_nxt;
      r_addr     <= w_addr_nxt;
      r_cr0      <= w_cr0_nxt;
      r_dq_out   <= w_dq_out_nxt;
      r_dq_oe    <= w_dq_oe_nxt;
      r_rwds_oe  <= w_rwds_oe_nxt;
      r_rwds_ris <= w_rwds_ris_nxt;
      r_rwds_fal <= w_rwds_fal_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  // Byte-masked array write; RWDS high on a half masks that byte.
  always_ff @(posedge clk) begin
    if (resetn && w_mem_we) begin
      if (!rwds_in_ris) r_mem[r_addr][15:8] <= dq_in_ris;
      if (!rwds_in_fal) r_mem[r_addr][7:0]  <= dq_in_fal;
    end
  end

  assign dq_out_ris   = r_dq_out[15:8];
  assign dq_out_fal   = r_dq_out[7:0];
  assign dq_oe        = r_dq_oe;
  assign rwds_out_ris = r_rwds_ris;
  assign rwds_out_fal = r_rwds_fal;
  assign rwds_oe      = r_rwds_oe;
  assign cr0          = r_cr0;
  assign abort        = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_psram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psram_responder
//  Purpose  : Directed self-checking bench for psram_responder. Read data is
//             predicted from a word model and queued when the CA is issued,
//             then popped and compared as each data beat appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cs_n;
  logic [7:0]  dq_in_ris, dq_in_fal;
  logic        rwds_in_ris, rwds_in_fal, force_2x;
  logic [7:0]  dq_out_ris, dq_out_fal;
  logic        dq_oe, rwds_out_ris, rwds_out_fal, rwds_oe, abort;
  logic [15:0] cr0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model [0:4095];
  logic [15:0] exp_q [$];
  logic [17:0] wd_q  [$];   // {mask_ris, mask_fal, data}
  logic [15:0] exp_cr0;

  psram_responder #(.ADDR_BITS(12), .CR0_RESET(16'h8F1F)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cs_n         (cs_n),
    .dq_in_ris    (dq_in_ris),
    .dq_in_fal    (dq_in_fal),
    .rwds_in_ris  (rwds_in_ris),
    .rwds_in_fal  (rwds_in_fal),
    .force_2x     (force_2x),
    .dq_out_ris   (dq_out_ris),
    .dq_out_fal   (dq_out_fal),
    .dq_oe        (dq_oe),
    .rwds_out_ris (rwds_out_ris),
    .rwds_out_fal (rwds_out_fal),
    .rwds_oe      (rwds_oe),
    .cr0          (cr0),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic cyc(input logic cs, input logic [7:0] r = 8'h00, input logic [7:0] f = 8'h00,
                     input logic mr = 1'b0, input logic mf = 1'b0, input logic f2x = 1'b0);
    cs_n = cs; dq_in_ris = r; dq_in_fal = f;
    rwds_in_ris = mr; rwds_in_fal = mf; force_2x = f2x;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ca(input logic [47:0] ca, input logic f2x, input logic dbl);
    logic [47:0] c;
    c = ca;
    cyc(1'b0, c[47:40], c[39:32], 1'b0, 1'b0, f2x);
    chk("c0_abort", 16'(abort), 16'h0);
    chk("c0_rwds", {13'h0, rwds_oe, rwds_out_ris, rwds_out_fal}, {13'h0, 1'b1, dbl, dbl});
    cyc(1'b0, c[31:24], c[23:16]);
    cyc(1'b0, c[15:8], c[7:0]);
    chk("c2_rwds", {13'h0, rwds_oe, rwds_out_ris, rwds_out_fal}, {13'h0, 1'b1, dbl, dbl});
  endtask

  task automatic write_burst(input logic [47:0] ca, input int addr, input logic dbl, input int latc);
    int a;
    logic [17:0] w;
    a = addr;
    send_ca(ca, 1'b0, dbl);
    repeat (latc) cyc(1'b0, 8'hDE, 8'hAD);
    while (wd_q.size() > 0) begin
      w = wd_q.pop_front();
      cyc(1'b0, w[15:8], w[7:0], w[17], w[16]);
      if (!w[17]) model[a][15:8] = w[15:8];
      if (!w[16]) model[a][7:0]  = w[7:0];
      a = (a + 1) % 4096;
    end
    cyc(1'b1);
  endtask

  task automatic read_burst(input logic [47:0] ca, input int addr, input int n, input logic isreg,
                            input logic f2x, input logic dbl, input int latc);
    logic [15:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(isreg ? exp_cr0 : model[(addr + i) % 4096]);
    send_ca(ca, f2x, dbl);
    for (int i = 0; i < latc; i++) begin
      cyc(1'b0);
      if (i == latc - 1) chk("lat_no_drive", {14'h0, dq_oe, rwds_oe}, 16'h0);
    end
    for (int i = 0; i < n; i++) begin
      cyc(1'b0);
      e = exp_q.pop_front();
      chk("rd_data", {dq_out_ris, dq_out_fal}, e);
      if (i == 0) chk("rd_strobe", {12'h0, dq_oe, rwds_oe, rwds_out_ris, rwds_out_fal}, 16'h000E);
    end
    cyc(1'b1);
    chk("rd_release", {14'h0, dq_oe, rwds_oe}, 16'h0);
  endtask

  initial begin
    logic [15:0] e;
    resetn = 1'b0;
    exp_cr0 = 16'h8F1F;
    repeat (3) cyc(1'b1);
    chk("rst_cr0", cr0, 16'h8F1F);
    chk("rst_oe", {13'h0, dq_oe, rwds_oe, abort}, 16'h0);
    chk("rst_dq", {dq_out_ris, dq_out_fal}, 16'h0);
    chk("rst_rwds", {14'h0, rwds_out_ris, rwds_out_fal}, 16'h0);
    resetn = 1'b1;
    cyc(1'b1);

    // CR0 write: reset CR0 has fixed-2x set, so RWDS is high during the CA.
    send_ca(48'h6000_0100_0000, 1'b0, 1'b1);
    cyc(1'b0, 8'h8F, 8'hE7);
    exp_cr0 = 16'h8FE7;
    chk("regw_cr0", cr0, 16'h8FE7);
    cyc(1'b0, 8'h11, 8'h22);
    chk("regw_ignore", cr0, 16'h8FE7);
    cyc(1'b1);

    // Memory write words 5,6 then read them back at L=3, 1x.
    wd_q.push_back({2'b00, 16'hBEEF});
    wd_q.push_back({2'b00, 16'hCAFE});
    write_burst(48'h0000_0000_0005, 5, 1'b0, 1);
    read_burst(48'h8000_0000_0005, 5, 2, 1'b0, 1'b0, 1'b0, 1);

    // Upper byte masked: only the lower byte is written.
    wd_q.push_back({2'b10, 16'h1234});
    write_burst(48'h0000_0000_0005, 5, 1'b0, 1);
    read_burst(48'h8000_0000_0005, 5, 1, 1'b0, 1'b0, 1'b0, 1);
    chk("bytemask_model", model[5], 16'hBE34);

    // force_2x at C0: data at C0+7.
    read_burst(48'h8000_0000_0005, 5, 1, 1'b0, 1'b1, 1'b1, 4);

    // CA aborted at C1, then a new access on the very next low cycle.
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b1);
    chk("abort_pulse", 16'(abort), 16'h1);
    chk("abort_release", {14'h0, dq_oe, rwds_oe}, 16'h0);
    read_burst(48'h8000_0000_0005, 5, 1, 1'b0, 1'b0, 1'b0, 1);

    // Wrap: last word then word 0, in both directions.
    wd_q.push_back({2'b00, 16'hA5A5});
    wd_q.push_back({2'b00, 16'h5A5A});
    write_burst(48'h0000_01FF_0007, 4095, 1'b0, 1);
    read_burst(48'h8000_01FF_0007, 4095, 2, 1'b0, 1'b0, 1'b0, 1);
    chk("wrap_model", model[0], 16'h5A5A);

    // Register-space read returns CR0.
    read_burst(48'hC000_0000_0000, 0, 1, 1'b1, 1'b0, 1'b0, 1);

    // Reset in the middle of a read burst.
    send_ca(48'h8000_0000_0006, 1'b0, 1'b0);
    cyc(1'b0);
    cyc(1'b0);
    chk("pre_rst_data", {dq_out_ris, dq_out_fal}, model[6]);
    resetn = 1'b0;
    cyc(1'b0);
    exp_cr0 = 16'h8F1F;
    chk("midrst_cr0", cr0, 16'h8F1F);
    chk("midrst_oe", {14'h0, dq_oe, rwds_oe}, 16'h0);
    resetn = 1'b1;
    cyc(1'b1);

    // Back at reset CR0: L=6, fixed 2x -> data at C0+13.
    read_burst(48'h8000_0000_0005, 5, 1, 1'b0, 1'b0, 1'b1, 10);

    e = 16'h0;
    chk("queue_empty", 16'(exp_q.size()), e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
